// File: rtl/qspi_mem_pkg.sv
// ============================================================================
// Module      : qspi_mem_pkg
// Description : Shared sizing helpers for the QSPI / UL shared word buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qspi_mem_pkg;

    localparam int c_BYTE_BITS = 8;

    function automatic int lane_count(input int data_width);
        return data_width / c_BYTE_BITS;
    endfunction

    // A limit of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int starve_cnt_width(input int starve_limit);
        int w;
        w = $clog2(starve_limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qspi_mem_port_arb.sv
// ============================================================================
// Module      : qspi_mem_port_arb
// Description : Two-requester arbiter, QSPI preferred, UL granted after a
//               bounded number of consecutive lost contests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_mem_port_arb
    import qspi_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_q,
    input  logic i_req_u,
    output logic o_gnt_q,
    output logic o_gnt_u
);

    localparam int              c_CW    = starve_cnt_width(STARVE_LIMIT);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic            c_FAIR  = (STARVE_LIMIT != 0);

    logic [c_CW-1:0] r_starve_cnt;
    logic            w_ul_turn;
    logic            w_contend;

    assign w_contend = i_req_q & i_req_u;
    assign w_ul_turn = c_FAIR & (r_starve_cnt == c_LIMIT);

    assign o_gnt_u = i_req_u & (~i_req_q | w_ul_turn);
    assign o_gnt_q = i_req_q & ~(i_req_u & w_ul_turn);

    // Counts consecutive contests UL lost; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (o_gnt_u) begin
            r_starve_cnt <= '0;
        end else if (w_contend && (r_starve_cnt != c_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qspi_mem_buf_arb.sv
// ============================================================================
// Module      : qspi_mem_buf_arb
// Description : Shared simple-dual-port word buffer between the QSPI flash
//               engine and the UL register bus, with per-port arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_mem_buf_arb
    import qspi_mem_pkg::*;
#(
    parameter int MEM_ADDRBITS = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDRBITS-1:0]   mem_ul_waddr,
    input  logic [DATA_WIDTH-1:0]     mem_ul_wdata,
    input  logic [DATA_WIDTH/8-1:0]   mem_ul_wstrb,
    input  logic                      mem_ul_wvalid,
    output logic                      mem_ul_wready,
    input  logic [MEM_ADDRBITS-1:0]   mem_ul_araddr,
    input  logic                      mem_ul_arvalid,
    output logic                      mem_ul_arready,
    output logic [DATA_WIDTH-1:0]     mem_ul_rdata,
    output logic                      mem_ul_rvalid,
    input  logic                      mem_ul_rready,
    input  logic [MEM_ADDRBITS-1:0]   qspimem_addr,
    input  logic                      qspimem_valid,
    input  logic                      qspimem_wr,
    input  logic [DATA_WIDTH-1:0]     qspimem_out_data,
    output logic                      qspimem_ready,
    output logic [DATA_WIDTH-1:0]     qspimem_in_data,
    output logic                      qspimem_in_valid
);

    localparam int c_LANES = lane_count(DATA_WIDTH);
    localparam int c_DEPTH = 2 ** MEM_ADDRBITS;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_req_qw, w_req_uw, w_req_qr, w_req_ur, w_slot_free;
    logic                  w_gnt_qw, w_gnt_uw, w_gnt_qr, w_gnt_ur;
    logic                  r_ul_rvalid, r_q_rvalid;
    logic [DATA_WIDTH-1:0] r_ul_rdata, r_q_rdata;

    // UL may only take the read port when its output register can be refilled.
    assign w_slot_free = ~r_ul_rvalid | mem_ul_rready;
    assign w_req_qw    = qspimem_valid & qspimem_wr;
    assign w_req_uw    = mem_ul_wvalid;
    assign w_req_qr    = qspimem_valid & ~qspimem_wr;
    assign w_req_ur    = mem_ul_arvalid & w_slot_free;

    qspi_mem_port_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req_q (w_req_qw),
        .i_req_u (w_req_uw),
        .o_gnt_q (w_gnt_qw),
        .o_gnt_u (w_gnt_uw)
    );

    qspi_mem_port_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req_q (w_req_qr),
        .i_req_u (w_req_ur),
        .o_gnt_q (w_gnt_qr),
        .o_gnt_u (w_gnt_ur)
    );

    assign qspimem_ready  = qspimem_wr ? w_gnt_qw : w_gnt_qr;
    assign mem_ul_wready  = w_gnt_uw;
    assign mem_ul_arready = w_gnt_ur;

    // Write port; grants are mutually exclusive so one writer per cycle.
    always_ff @(posedge clk) begin
        if (w_gnt_qw) begin
            r_mem[qspimem_addr] <= qspimem_out_data;
        end else if (w_gnt_uw) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (mem_ul_wstrb[i]) begin
                    r_mem[mem_ul_waddr][i*8 +: 8] <= mem_ul_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read port; sampling before the write lands gives read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q_rvalid  <= 1'b0;
            r_q_rdata   <= '0;
            r_ul_rvalid <= 1'b0;
            r_ul_rdata  <= '0;
        end else begin
            r_q_rvalid <= w_gnt_qr;
            if (w_gnt_qr) begin
                r_q_rdata <= r_mem[qspimem_addr];
            end
            if (w_gnt_ur) begin
                r_ul_rvalid <= 1'b1;
                r_ul_rdata  <= r_mem[mem_ul_araddr];
            end else if (mem_ul_rready) begin
                r_ul_rvalid <= 1'b0;
            end
        end
    end

    assign qspimem_in_valid = r_q_rvalid;
    assign qspimem_in_data  = r_q_rdata;
    assign mem_ul_rvalid    = r_ul_rvalid;
    assign mem_ul_rdata     = r_ul_rdata;

endmodule

`default_nettype wire

// File: tb/tb_qspi_mem_buf_arb.sv
// ============================================================================
// Module      : tb_qspi_mem_buf_arb
// Description : Self-checking bench: directed vector table, starvation and
//               reset sequences, then randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_mem_buf_arb;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] mem_ul_waddr, mem_ul_araddr, qspimem_addr;
    logic [DW-1:0] mem_ul_wdata, qspimem_out_data;
    logic [3:0]    mem_ul_wstrb;
    logic          mem_ul_wvalid, mem_ul_arvalid, mem_ul_rready;
    logic          qspimem_valid, qspimem_wr;
    logic          mem_ul_wready, mem_ul_arready, mem_ul_rvalid;
    logic          qspimem_ready, qspimem_in_valid;
    logic [DW-1:0] mem_ul_rdata, qspimem_in_data;
    logic          z_wready, z_arready, z_rvalid, z_qready, z_qvalid;
    logic [DW-1:0] z_rdata, z_qdata;

    always #5 clk = ~clk;

    qspi_mem_buf_arb #(.MEM_ADDRBITS(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .mem_ul_waddr(mem_ul_waddr), .mem_ul_wdata(mem_ul_wdata), .mem_ul_wstrb(mem_ul_wstrb),
        .mem_ul_wvalid(mem_ul_wvalid), .mem_ul_wready(mem_ul_wready),
        .mem_ul_araddr(mem_ul_araddr), .mem_ul_arvalid(mem_ul_arvalid), .mem_ul_arready(mem_ul_arready),
        .mem_ul_rdata(mem_ul_rdata), .mem_ul_rvalid(mem_ul_rvalid), .mem_ul_rready(mem_ul_rready),
        .qspimem_addr(qspimem_addr), .qspimem_valid(qspimem_valid), .qspimem_wr(qspimem_wr),
        .qspimem_out_data(qspimem_out_data), .qspimem_ready(qspimem_ready),
        .qspimem_in_data(qspimem_in_data), .qspimem_in_valid(qspimem_in_valid)
    );

    // Strict-priority variant sharing the same stimulus.
    qspi_mem_buf_arb #(.MEM_ADDRBITS(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .mem_ul_waddr(mem_ul_waddr), .mem_ul_wdata(mem_ul_wdata), .mem_ul_wstrb(mem_ul_wstrb),
        .mem_ul_wvalid(mem_ul_wvalid), .mem_ul_wready(z_wready),
        .mem_ul_araddr(mem_ul_araddr), .mem_ul_arvalid(mem_ul_arvalid), .mem_ul_arready(z_arready),
        .mem_ul_rdata(z_rdata), .mem_ul_rvalid(z_rvalid), .mem_ul_rready(mem_ul_rready),
        .qspimem_addr(qspimem_addr), .qspimem_valid(qspimem_valid), .qspimem_wr(qspimem_wr),
        .qspimem_out_data(qspimem_out_data), .qspimem_ready(z_qready),
        .qspimem_in_data(z_qdata), .qspimem_in_valid(z_qvalid)
    );

    typedef struct {
        logic uwv; logic [5:0] wa; logic [31:0] wd; logic [3:0] ws;
        logic uav; logic [5:0] ra; logic rr;
        logic qv;  logic qw; logic [5:0] qa; logic [31:0] qd;
        logic ewr; logic ear; logic eq;
        logic erv; logic [31:0] erd;
        logic eqv; logic [31:0] eqd;
    } vec_t;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    vec_t tv[27];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory image, UL loss streaks, pending read results.
    logic [31:0] m_mem [64];
    int          m_wcnt, m_rcnt;
    logic        m_rv, m_qv;
    logic [31:0] m_rd, m_qd;
    logic        acc_q, acc_uw, acc_ur;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void arb2(input logic rq, input logic ru, input int streak,
                                 output logic gq, output logic gu);
        logic ul_turn;
        ul_turn = rq && ru && (SL != 0) && (streak == SL);
        gu = ru && (!rq || ul_turn);
        gq = rq && !ul_turn;
    endfunction

    function automatic int next_streak(input logic won, input logic contended, input int streak);
        if (won)       return 0;
        if (contended) return (streak < SL) ? streak + 1 : SL;
        return streak;
    endfunction

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_rv = 1'b0; m_qv = 1'b0; m_rd = '0; m_qd = '0;
    endtask

    // Called at the negedge: checks current outputs, then advances the model.
    task automatic model_step();
        logic qw, uw, qr, ur, gqw, guw, gqr, gur;
        qw = qspimem_valid && qspimem_wr;
        uw = mem_ul_wvalid;
        qr = qspimem_valid && !qspimem_wr;
        ur = mem_ul_arvalid && (!m_rv || mem_ul_rready);
        arb2(qw, uw, m_wcnt, gqw, guw);
        arb2(qr, ur, m_rcnt, gqr, gur);
        chk1("m_wready", mem_ul_wready, guw);
        chk1("m_arready", mem_ul_arready, gur);
        chk1("m_qready", qspimem_ready, qspimem_wr ? gqw : gqr);
        chk1("m_rvalid", mem_ul_rvalid, m_rv);
        if (m_rv) chk32("m_rdata", mem_ul_rdata, m_rd);
        chk1("m_qvalid", qspimem_in_valid, m_qv);
        if (m_qv) chk32("m_qdata", qspimem_in_data, m_qd);
        m_qv = gqr;
        if (gqr) m_qd = m_mem[qspimem_addr];
        if (gur) begin
            m_rv = 1'b1;
            m_rd = m_mem[mem_ul_araddr];
        end else if (mem_ul_rready) begin
            m_rv = 1'b0;
        end
        if (gqw) m_mem[qspimem_addr] = qspimem_out_data;
        if (guw) begin
            for (int i = 0; i < 4; i++)
                if (mem_ul_wstrb[i]) m_mem[mem_ul_waddr][i*8 +: 8] = mem_ul_wdata[i*8 +: 8];
        end
        m_wcnt = next_streak(guw, qw && uw, m_wcnt);
        m_rcnt = next_streak(gur, qr && ur, m_rcnt);
        acc_q  = qspimem_wr ? gqw : gqr;
        acc_uw = guw;
        acc_ur = gur;
    endtask

    task automatic idle_inputs();
        mem_ul_wvalid = 1'b0; mem_ul_arvalid = 1'b0; qspimem_valid = 1'b0;
        qspimem_wr = 1'b0; mem_ul_rready = 1'b1;
        mem_ul_waddr = '0; mem_ul_wdata = '0; mem_ul_wstrb = '0;
        mem_ul_araddr = '0; qspimem_addr = '0; qspimem_out_data = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        mem_ul_wvalid = v.uwv; mem_ul_waddr = v.wa; mem_ul_wdata = v.wd; mem_ul_wstrb = v.ws;
        mem_ul_arvalid = v.uav; mem_ul_araddr = v.ra; mem_ul_rready = v.rr;
        qspimem_valid = v.qv; qspimem_wr = v.qw; qspimem_addr = v.qa; qspimem_out_data = v.qd;
    endtask

    initial begin
        // uwv wa wd ws | uav ra rr | qv qw qa qd | ewr ear eq | erv erd | eqv eqd
        tv[0]  = '{T, 6'd5, 32'hDEADBEEF, 4'hF, F, 6'd0, T, F, F, 6'd0, '0, T, F, F, F, '0, F, '0};
        tv[1]  = '{F, 6'd0, '0, 4'h0, T, 6'd5, T, F, F, 6'd0, '0, F, T, F, F, '0, F, '0};
        tv[2]  = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, T, 32'hDEADBEEF, F, '0};
        tv[3]  = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, F, '0, F, '0};
        tv[4]  = '{T, 6'd3, 32'h11223344, 4'hF, F, 6'd0, T, F, F, 6'd0, '0, T, F, F, F, '0, F, '0};
        tv[5]  = '{T, 6'd3, 32'hAABBCCDD, 4'h5, F, 6'd0, T, F, F, 6'd0, '0, T, F, F, F, '0, F, '0};
        tv[6]  = '{F, 6'd0, '0, 4'h0, T, 6'd3, T, F, F, 6'd0, '0, F, T, F, F, '0, F, '0};
        tv[7]  = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, T, 32'h11BB33DD, F, '0};
        tv[8]  = '{T, 6'd3, 32'hFFFFFFFF, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, T, F, F, F, '0, F, '0};
        tv[9]  = '{F, 6'd0, '0, 4'h0, T, 6'd3, T, F, F, 6'd0, '0, F, T, F, F, '0, F, '0};
        tv[10] = '{F, 6'd0, '0, 4'h0, T, 6'd5, F, F, F, 6'd0, '0, F, F, F, T, 32'h11BB33DD, F, '0};
        tv[11] = '{F, 6'd0, '0, 4'h0, T, 6'd5, F, F, F, 6'd0, '0, F, F, F, T, 32'h11BB33DD, F, '0};
        tv[12] = '{F, 6'd0, '0, 4'h0, T, 6'd5, F, F, F, 6'd0, '0, F, F, F, T, 32'h11BB33DD, F, '0};
        tv[13] = '{F, 6'd0, '0, 4'h0, T, 6'd5, T, F, F, 6'd0, '0, F, T, F, T, 32'h11BB33DD, F, '0};
        tv[14] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, T, 32'hDEADBEEF, F, '0};
        tv[15] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, F, '0, F, '0};
        tv[16] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, T, T, 6'd7, 32'h9, F, F, T, F, '0, F, '0};
        tv[17] = '{F, 6'd0, '0, 4'h0, T, 6'd7, T, T, T, 6'd7, 32'h5, F, T, T, F, '0, F, '0};
        tv[18] = '{F, 6'd0, '0, 4'h0, T, 6'd7, T, F, F, 6'd0, '0, F, T, F, T, 32'h9, F, '0};
        tv[19] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, T, 32'h5, F, '0};
        tv[20] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, T, F, 6'd5, '0, F, F, T, F, '0, F, '0};
        tv[21] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, F, '0, T, 32'hDEADBEEF};
        tv[22] = '{T, 6'd3, 32'h77777777, 4'hF, F, 6'd0, T, T, F, 6'd3, '0, T, F, T, F, '0, F, '0};
        tv[23] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, T, F, 6'd3, '0, F, F, T, F, '0, T, 32'h11BB33DD};
        tv[24] = '{F, 6'd0, '0, 4'h0, F, 6'd0, T, F, F, 6'd0, '0, F, F, F, F, '0, T, 32'h77777777};
        tv[25] = '{T, 6'd10, 32'h2, 4'hF, F, 6'd0, T, T, T, 6'd10, 32'h1, F, F, T, F, '0, F, '0};
        tv[26] = '{T, 6'd10, 32'h2, 4'hF, F, 6'd0, T, F, F, 6'd0, '0, T, F, F, F, '0, F, '0};

        idle_inputs();
        model_reset();
        acc_q = 1'b1; acc_uw = 1'b1; acc_ur = 1'b1;

        // Reset state, and readies evaluated from cleared counters.
        #3;
        chk1("rst_rvalid", mem_ul_rvalid, 1'b0);
        chk1("rst_qvalid", qspimem_in_valid, 1'b0);
        chk32("rst_rdata", mem_ul_rdata, 32'h0);
        chk32("rst_qdata", qspimem_in_data, 32'h0);
        qspimem_valid = 1'b1; mem_ul_arvalid = 1'b1;
        #1;
        chk1("rst_qready", qspimem_ready, 1'b1);
        chk1("rst_arready", mem_ul_arready, 1'b0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill the whole buffer so every later read has a defined value.
        for (int a = 0; a < 64; a++) begin
            qspimem_valid = 1'b1; qspimem_wr = 1'b1;
            qspimem_addr = 6'(a); qspimem_out_data = 32'hA5000000 | 32'(a);
            tick();
        end
        idle_inputs();

        for (int r = 0; r < 27; r++) begin
            apply(tv[r]);
            @(negedge clk);
            chk1($sformatf("v%0d_wready", r), mem_ul_wready, tv[r].ewr);
            chk1($sformatf("v%0d_arready", r), mem_ul_arready, tv[r].ear);
            chk1($sformatf("v%0d_qready", r), qspimem_ready, tv[r].eq);
            chk1($sformatf("v%0d_rvalid", r), mem_ul_rvalid, tv[r].erv);
            if (tv[r].erv) chk32($sformatf("v%0d_rdata", r), mem_ul_rdata, tv[r].erd);
            chk1($sformatf("v%0d_qvalid", r), qspimem_in_valid, tv[r].eqv);
            if (tv[r].eqv) chk32($sformatf("v%0d_qdata", r), qspimem_in_data, tv[r].eqd);
            model_step();
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // Contended read port: UL wins every 5th cycle; strict variant never.
        qspimem_valid = 1'b1; qspimem_wr = 1'b0; qspimem_addr = 6'd1;
        mem_ul_arvalid = 1'b1; mem_ul_araddr = 6'd5; mem_ul_rready = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk1($sformatf("starve%0d_arready", k), mem_ul_arready, (k % 5) == 0);
            chk1($sformatf("starve%0d_qready", k), qspimem_ready, (k % 5) != 0);
            chk1($sformatf("strict%0d_arready", k), z_arready, 1'b0);
            chk1($sformatf("strict%0d_qready", k), z_qready, 1'b1);
            model_step();
            @(posedge clk);
            #1;
        end
        idle_inputs();
        tick();

        // Reset while a UL result is held and a QSPI read result is in flight.
        mem_ul_arvalid = 1'b1; mem_ul_araddr = 6'd5; mem_ul_rready = 1'b0;
        tick();
        mem_ul_arvalid = 1'b0;
        qspimem_valid = 1'b1; qspimem_wr = 1'b0; qspimem_addr = 6'd3;
        tick();
        chk1("pre_rst_rvalid", mem_ul_rvalid, 1'b1);
        chk1("pre_rst_qvalid", qspimem_in_valid, 1'b1);
        idle_inputs();
        mem_ul_rready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk1("arst_rvalid", mem_ul_rvalid, 1'b0);
        chk1("arst_qvalid", qspimem_in_valid, 1'b0);
        chk32("arst_rdata", mem_ul_rdata, 32'h0);
        chk32("arst_qdata", qspimem_in_data, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("post_rst_rvalid", mem_ul_rvalid, 1'b0);
            chk1("post_rst_qvalid", qspimem_in_valid, 1'b0);
            model_step();
            @(posedge clk);
            #1;
        end

        // Randomized traffic; ungranted requests hold their payload.
        acc_q = 1'b1; acc_uw = 1'b1; acc_ur = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (!qspimem_valid || acc_q) begin
                qspimem_valid    = ($urandom_range(0, 3) != 0);
                qspimem_wr       = 1'($urandom_range(0, 1));
                qspimem_addr     = 6'($urandom_range(0, 15));
                qspimem_out_data = $urandom;
            end
            if (!mem_ul_wvalid || acc_uw) begin
                mem_ul_wvalid = ($urandom_range(0, 2) != 0);
                mem_ul_waddr  = 6'($urandom_range(0, 15));
                mem_ul_wdata  = $urandom;
                mem_ul_wstrb  = 4'($urandom_range(0, 15));
            end
            if (!mem_ul_arvalid || acc_ur) begin
                mem_ul_arvalid = ($urandom_range(0, 2) != 0);
                mem_ul_araddr  = 6'($urandom_range(0, 15));
            end
            mem_ul_rready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
